// File: rtl/lsu_mem_fsm.sv
// rtl/lsu_mem_fsm.sv - load/store unit data-memory sequencer (optional LSU_TIMEOUT_EN request timeout)
module lsu_mem_fsm #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_valid,
  input  logic [3:0]  i_lsu_op,
  input  logic        i_mem_wren,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LBU = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  state_t state_q, state_d;

  logic        is_byte, is_half, is_word;
  logic        op_legal, op_misaligned;
  logic [3:0]  bmask_c;
  logic [31:0] wdata_c;
  logic        accept, reject, ack_take;
  logic        timeout_hit;

  logic [31:0] addr_q;
  logic [1:0]  lo_q;
  logic [3:0]  op_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  bmask_q;
  logic [31:0] ld_data_q;
  logic        mis_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode the presented op: access size, legality, alignment, lane mask and replicated store data
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (i_lsu_op)
      OP_LB, OP_LBU, OP_SB: is_byte = 1'b1;
      OP_LH, OP_LHU, OP_SH: is_half = 1'b1;
      OP_LW, OP_SW:         is_word = 1'b1;
      default: ;
    endcase
    op_legal      = (is_byte || is_half || is_word) && (i_mem_wren == i_lsu_op[3]);
    op_misaligned = (is_half && i_addr[0]) || (is_word && (i_addr[1:0] != 2'b00));
    bmask_c = 4'b1111;
    wdata_c = i_st_data;
    if (is_byte) begin
      bmask_c = 4'b0001 << i_addr[1:0];
      wdata_c = {4{i_st_data[7:0]}};
    end else if (is_half) begin
      bmask_c = 4'b0011 << {i_addr[1], 1'b0};
      wdata_c = {2{i_st_data[15:0]}};
    end
  end

  // Pick the addressed lane out of the read word and extend it according to the captured op
  always_comb begin
    ld_byte = i_mem_rdata[{lo_q, 3'b000} +: 8];
    ld_half = i_mem_rdata[{lo_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      OP_LW:   ld_ext = i_mem_rdata;
      default: ld_ext = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state control outputs; ack outside REQ falls through untouched
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    ack_take  = 1'b0;
    o_stall   = 1'b0;
    o_done    = 1'b0;
    o_mem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_stall = i_lsu_valid;
        if (i_lsu_valid) begin
          if (op_legal && !op_misaligned) begin
            accept  = 1'b1;
            state_d = S_REQ;
          end else begin
            reject  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          ack_take = 1'b1;
          state_d  = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields latched on accept, result latched on ack; reset discards everything in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q    <= 32'd0;
      lo_q      <= 2'd0;
      op_q      <= 4'd0;
      we_q      <= 1'b0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      ld_data_q <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= {i_addr[31:2], 2'b00};
        lo_q      <= i_addr[1:0];
        op_q      <= i_lsu_op;
        we_q      <= i_mem_wren;
        wdata_q   <= wdata_c;
        bmask_q   <= bmask_c;
        ld_data_q <= 32'd0;
        mis_q     <= 1'b0;
      end
      if (reject) begin
        ld_data_q <= 32'd0;
        mis_q     <= op_legal && op_misaligned;
      end
      if (ack_take) begin
        ld_data_q <= ld_ext;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tcnt_q;
  logic          err_q;

  assign timeout_hit = (state_q == S_REQ) && (tcnt_q == TLIM);

  // Count unanswered REQ cycles; an ack on the limit cycle still completes normally
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == S_REQ) && (state_d == S_REQ)) begin
        tcnt_q <= tcnt_q + 1'b1;
      end else begin
        tcnt_q <= '0;
      end
      if (accept || reject) begin
        err_q <= 1'b0;
      end else if (timeout_hit && !i_mem_ack) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_bus_err = o_done && err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign o_bus_err      = 1'b0;
`endif

  assign o_mem_we     = o_mem_req && we_q;
  assign o_mem_addr   = o_mem_req ? addr_q  : 32'd0;
  assign o_mem_wdata  = o_mem_req ? wdata_q : 32'd0;
  assign o_mem_bmask  = o_mem_req ? bmask_q : 4'd0;
  assign o_ld_data    = o_done ? ld_data_q : 32'd0;
  assign o_misaligned = o_done && mis_q;

endmodule

// File: tb/tb_lsu_mem_fsm.sv
// tb/tb_lsu_mem_fsm.sv - directed self-checking bench for lsu_mem_fsm
module tb_lsu_mem_fsm;

`ifdef LSU_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 255;
`endif

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LBU = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  logic        clk = 1'b0;
  logic        reset, lsu_valid, mem_wren, mem_ack;
  logic [3:0]  lsu_op;
  logic [31:0] addr, st_data, mem_rdata;
  logic        o_stall, o_done, o_misaligned, o_bus_err, o_mem_req, o_mem_we;
  logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;

  always #5 clk = ~clk;

  lsu_mem_fsm #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .i_clk(clk), .i_reset(reset), .i_lsu_valid(lsu_valid), .i_lsu_op(lsu_op),
    .i_mem_wren(mem_wren), .i_addr(addr), .i_st_data(st_data),
    .o_stall(o_stall), .o_done(o_done), .o_ld_data(o_ld_data),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        exp_stall, exp_done, exp_mis, exp_err, exp_req, exp_we;
  logic [31:0] exp_ld, exp_addr, exp_wdata;
  logic [3:0]  exp_bmask;

  int          req_run = 0;
  int          done_req_run = 0;
  logic [31:0] last_ld, last_req_addr, last_wdata;
  logic [3:0]  last_bmask;
  logic        last_mis, last_err, last_we;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] ld;
  } acc_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // kind: 0 accepted, 1 misaligned, 2 illegal
  function automatic acc_t model(input logic [3:0] op, input logic wren,
                                 input logic [31:0] a, input logic [31:0] st, input logic [31:0] rd);
    acc_t r;
    int size, off;
    logic [31:0] mask, v;
    r.kind = 2; r.we = 1'b0; r.waddr = 32'd0; r.wdata = 32'd0; r.bmask = 4'd0; r.ld = 32'd0;
    case (op)
      OP_LB, OP_LBU, OP_SB: size = 1;
      OP_LH, OP_LHU, OP_SH: size = 2;
      OP_LW, OP_SW:         size = 4;
      default:              size = 0;
    endcase
    off = int'(a % 32'd4);
    if (size == 0 || wren != op[3]) r.kind = 2;
    else if (off % size != 0) r.kind = 1;
    else begin
      r.kind  = 0;
      r.we    = op[3];
      r.waddr = a - 32'(off);
      r.bmask = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = st[8*(i % size) +: 8];
      if (!op[3]) begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        v = (rd >> (8*off)) & mask;
        if (size < 4 && op[0] == 1'b0 && v[8*size-1]) v = v | ~mask;
        r.ld = v;
      end
    end
    return r;
  endfunction

  task automatic exp_idle(input logic stall);
    exp_stall = stall; exp_done = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
    exp_req = 1'b0; exp_we = 1'b0; exp_ld = 32'd0; exp_addr = 32'd0;
    exp_wdata = 32'd0; exp_bmask = 4'd0;
  endtask

  task automatic compare_all();
    chk("stall",      32'(o_stall),      32'(exp_stall));
    chk("done",       32'(o_done),       32'(exp_done));
    chk("ld_data",    o_ld_data,         exp_ld);
    chk("misaligned", 32'(o_misaligned), 32'(exp_mis));
    chk("bus_err",    32'(o_bus_err),    32'(exp_err));
    chk("mem_req",    32'(o_mem_req),    32'(exp_req));
    chk("mem_we",     32'(o_mem_we),     32'(exp_we));
    chk("mem_addr",   o_mem_addr,        exp_addr);
    chk("mem_wdata",  o_mem_wdata,       exp_wdata);
    chk("mem_bmask",  32'(o_mem_bmask),  32'(exp_bmask));
  endtask

  task automatic observe();
    if (o_mem_req) begin
      req_run++;
      last_req_addr = o_mem_addr; last_wdata = o_mem_wdata;
      last_bmask = o_mem_bmask; last_we = o_mem_we;
    end
    if (o_done) begin
      done_req_run = req_run; req_run = 0;
      last_ld = o_ld_data; last_mis = o_misaligned; last_err = o_bus_err;
    end else if (!o_stall) begin
      req_run = 0;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the following falling edge
  task automatic tick();
    @(negedge clk);
    compare_all();
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic ack);
    lsu_valid = 1'b0; mem_ack = ack;
    exp_idle(1'b0);
    for (int i = 0; i < n; i++) tick();
    mem_ack = 1'b0;
  endtask

  task automatic do_access(input logic [3:0] op, input logic wren, input logic [31:0] a,
                           input logic [31:0] st, input logic [31:0] rd, input int wt);
    acc_t m;
    int   nreq;
    bit   tmo;
    m = model(op, wren, a, st, rd);
    tmo = 1'b0;
`ifdef LSU_TIMEOUT_EN
    if (m.kind == 0 && wt >= TB_TMO) tmo = 1'b1;
`endif
    lsu_valid = 1'b1; lsu_op = op; mem_wren = wren; addr = a; st_data = st;
    mem_ack = 1'b0; mem_rdata = 32'hA5A5_5A5A;
    exp_idle(1'b1);
    tick();
    if (m.kind == 0) begin
      nreq = tmo ? TB_TMO : wt + 1;
      for (int k = 0; k < nreq; k++) begin
        mem_ack   = (!tmo && k == wt);
        mem_rdata = mem_ack ? rd : 32'hA5A5_5A5A;
        exp_idle(1'b1);
        exp_req = 1'b1; exp_we = m.we; exp_addr = m.waddr;
        exp_wdata = m.wdata; exp_bmask = m.bmask;
        tick();
      end
      mem_ack = 1'b0;
    end
    exp_idle(1'b0);
    exp_done = 1'b1;
    exp_ld   = (m.kind == 0 && !tmo) ? m.ld : 32'd0;
    exp_mis  = (m.kind == 1);
    exp_err  = tmo;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    acc_t m;
    reset = 1'b1; lsu_valid = 1'b0; lsu_op = 4'd0; mem_wren = 1'b0; addr = 32'd0;
    st_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    @(posedge clk); #1;
    exp_idle(1'b0);
    tick();
    reset = 1'b0;
    idle_cycles(2, 1'b0);

    // stray ack while idle must be ignored
    idle_cycles(1, 1'b1);

    do_access(OP_LW, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    chk("t1_ld", last_ld, 32'hDEADBEEF);
    chk("t1_req_cycles", done_req_run, 1);
    chk("t1_addr", last_req_addr, 32'h100);
    chk("t1_bmask", 32'(last_bmask), 32'h0000_000F);

    do_access(OP_LB, 1'b0, 32'h103, 32'd0, 32'h80123456, 0);
    chk("t2_lb_ld", last_ld, 32'hFFFF_FF80);
    chk("t2_bmask", 32'(last_bmask), 32'h0000_0008);
    do_access(OP_LBU, 1'b0, 32'h103, 32'd0, 32'h80123456, 1);
    chk("t2_lbu_ld", last_ld, 32'h0000_0080);

    do_access(OP_SH, 1'b1, 32'h202, 32'h0000ABCD, 32'h5555AAAA, 3);
    chk("t3_we", 32'(last_we), 32'd1);
    chk("t3_addr", last_req_addr, 32'h200);
    chk("t3_wdata", last_wdata, 32'hABCDABCD);
    chk("t3_bmask", 32'(last_bmask), 32'h0000_000C);
    chk("t3_req_cycles", done_req_run, 4);
    chk("t3_ld", last_ld, 32'd0);

    do_access(OP_LW, 1'b0, 32'h101, 32'd0, 32'h12345678, 0);
    chk("t4_mis", 32'(last_mis), 32'd1);
    chk("t4_req_cycles", done_req_run, 0);

    // back-to-back mixed sizes, alignments, illegal codes and direction mismatches
    do_access(OP_LH,  1'b0, 32'h102, 32'd0, 32'h80017FFF, 2);
    chk("lh_ld", last_ld, 32'hFFFF_8001);
    do_access(OP_LHU, 1'b0, 32'h100, 32'd0, 32'h80017FFF, 0);
    chk("lhu_ld", last_ld, 32'h0000_7FFF);
    do_access(OP_LB,  1'b0, 32'h101, 32'd0, 32'h00007F00, 0);
    chk("lb_pos_ld", last_ld, 32'h0000_007F);
    do_access(OP_SB,  1'b1, 32'h101, 32'h12345678, 32'd0, 1);
    chk("sb_wdata", last_wdata, 32'h7878_7878);
    do_access(OP_SW,  1'b1, 32'h104, 32'hCAFEF00D, 32'd0, 0);
    do_access(OP_SH,  1'b1, 32'h203, 32'h1111, 32'd0, 0);
    do_access(OP_SW,  1'b1, 32'h206, 32'h1111, 32'd0, 0);
    do_access(4'b0101, 1'b0, 32'h100, 32'd0, 32'd0, 0);
    chk("illegal_mis", 32'(last_mis), 32'd0);
    do_access(OP_LW,  1'b1, 32'h100, 32'd0, 32'd0, 0);
    do_access(OP_SW,  1'b0, 32'h100, 32'd0, 32'd0, 0);
    do_access(4'b1011, 1'b1, 32'h100, 32'd0, 32'd0, 0);
    idle_cycles(1, 1'b0);
    do_access(OP_LW,  1'b0, 32'h10C, 32'd0, 32'h0BADC0DE, 3);
    chk("lw_wait3_ld", last_ld, 32'h0BADC0DE);
    do_access(OP_LW,  1'b0, 32'h110, 32'd0, 32'h600DF00D, 20);
    idle_cycles(1, 1'b0);

    // reset during REQ: request drops at the reset edge, no completion follows
    m = model(OP_LW, 1'b0, 32'h108, 32'd0, 32'd0);
    lsu_valid = 1'b1; lsu_op = OP_LW; mem_wren = 1'b0; addr = 32'h108; mem_rdata = 32'h11111111;
    exp_idle(1'b1);
    tick();
    exp_idle(1'b1);
    exp_req = 1'b1; exp_addr = m.waddr; exp_bmask = m.bmask; exp_wdata = m.wdata;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; lsu_valid = 1'b0;
    idle_cycles(1, 1'b1);
    idle_cycles(2, 1'b0);
    chk("t5_req_after_reset", 32'(o_mem_req), 32'd0);

`ifdef LSU_TIMEOUT_EN
    do_access(OP_LW, 1'b0, 32'h110, 32'd0, 32'h12345678, 1000);
    chk("t6_req_cycles", done_req_run, 4);
    chk("t6_bus_err", 32'(last_err), 32'd1);
    chk("t6_ld", last_ld, 32'd0);
    do_access(OP_LW, 1'b0, 32'h114, 32'd0, 32'h55667788, 3);
    chk("t6_limit_ack_err", 32'(last_err), 32'd0);
    chk("t6_limit_ack_ld", last_ld, 32'h55667788);
`endif

    idle_cycles(2, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
